// File: rtl/noc_output_port_if.sv
// Handshake bundle of a NoC router output port: crossbar side (data/valid/ready),
// downstream side (data/write_en/credit) and status.
interface noc_output_port_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CREDITS = 5,
  parameter int unsigned CW      = $clog2(CREDITS + 1)
);
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_o;
  logic             write_en_o;
  logic             credit_i;
  logic [CW-1:0]    credit_count_o;
  logic             empty_o;
  logic             credit_err_o;

  // Environment side: crossbar plus downstream input port.
  modport master (
    output data_i, valid_i, credit_i,
    input  ready_o, data_o, write_en_o, credit_count_o, empty_o, credit_err_o
  );

  // Output port side.
  modport slave (
    input  data_i, valid_i, credit_i,
    output ready_o, data_o, write_en_o, credit_count_o, empty_o, credit_err_o
  );
endinterface

// File: rtl/noc_output_port.sv
// NoC router output port: small local FIFO fed by the crossbar, draining to the
// neighbouring input port under credit-based flow control.
module noc_output_port #(
  parameter int unsigned  WIDTH   = 16,
  parameter int unsigned  DEPTH   = 4,
  parameter int unsigned  CREDITS = 5,
  localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
  input logic              clk,
  input logic              rst,
  noc_output_port_if.slave bus
);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [OW-1:0]    occ;
  logic [CW-1:0]    credits;
  logic [WIDTH-1:0] data_q;
  logic             we_q;
  logic             err_q;

  logic ready;
  logic push;
  logic send;

  // Handshake decode: ready comes from occupancy only; a returning credit
  // enables a send at the same edge, so a blocked head leaves immediately.
  always_comb begin
    ready = (occ != OW'(DEPTH));
    push  = bus.valid_i && ready;
    send  = (occ != '0) && ((credits != '0) || bus.credit_i);
  end

  // FIFO storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  // Pointers and occupancy; power-of-two depth gives natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (send) rd_ptr <= rd_ptr + 1'b1;
      case ({push, send})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Registered downstream output: head flit and one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= send;
      if (send) data_q <= mem[rd_ptr];
    end
  end

  // Credit counter with saturation and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(CREDITS);
      err_q   <= 1'b0;
    end else if (send && !bus.credit_i) begin
      credits <= credits - 1'b1;
    end else if (!send && bus.credit_i) begin
      if (credits == CW'(CREDITS)) begin
        err_q <= 1'b1;
      end else begin
        credits <= credits + 1'b1;
      end
    end
  end

  assign bus.ready_o        = ready;
  assign bus.empty_o        = (occ == '0);
  assign bus.credit_count_o = credits;
  assign bus.data_o         = data_q;
  assign bus.write_en_o     = we_q;
  assign bus.credit_err_o   = err_q;
endmodule

// File: tb/tb_noc_output_port.sv
// Self-checking bench for noc_output_port: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_noc_output_port;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CREDITS = 5;

  logic clk;
  logic rst;

  noc_output_port_if #(.WIDTH(WIDTH), .CREDITS(CREDITS)) bus ();

  noc_output_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .CREDITS(CREDITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_q[$];
  int               m_credits;
  bit               m_err;
  bit               m_we;
  logic [WIDTH-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input logic [WIDTH-1:0] d, input bit c, input bit r);
    bit can_send;
    bit can_push;
    if (r) begin
      m_q.delete();
      m_credits = CREDITS;
      m_err     = 0;
      m_we      = 0;
      m_data    = '0;
    end else begin
      can_send = (m_q.size() != 0) && (m_credits != 0 || c);
      can_push = v && (m_q.size() != DEPTH);
      m_we = can_send;
      if (can_send) m_data = m_q.pop_front();
      if (can_push) m_q.push_back(d);
      if (can_send && !c) m_credits--;
      else if (!can_send && c) begin
        if (m_credits == CREDITS) m_err = 1;
        else m_credits++;
      end
    end
  endtask

  task automatic compare_all();
    check("data_o",       32'(bus.data_o),         32'(m_data));
    check("write_en_o",   32'(bus.write_en_o),     32'(m_we));
    check("credit_count", 32'(bus.credit_count_o), 32'(m_credits));
    check("empty_o",      32'(bus.empty_o),        32'(m_q.size() == 0));
    check("ready_o",      32'(bus.ready_o),        32'(m_q.size() != DEPTH));
    check("credit_err_o", 32'(bus.credit_err_o),   32'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare after it.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit c, input bit r);
    bus.valid_i  = v;
    bus.data_i   = d;
    bus.credit_i = c;
    rst          = r;
    @(posedge clk);
    model_step(v, d, c, r);
    #1;
    compare_all();
  endtask

  int ds;
  bit rc;
  bit rv;
  bit rr;

  initial begin
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.credit_i = 1'b0;
    rst          = 1'b1;
    m_credits    = CREDITS;
    m_err        = 0;
    m_we         = 0;
    m_data       = '0;

    // Reset held two cycles.
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_credits", 32'(bus.credit_count_o), 32'd5);
    check("rst_we", 32'(bus.write_en_o), 32'd0);
    check("rst_data", 32'(bus.data_o), 32'd0);

    // Single flit: one-cycle latency.
    cycle(1, 16'h00A5, 0, 0);
    cycle(0, '0, 0, 0);
    check("single_data", 32'(bus.data_o), 32'h00A5);
    check("single_we", 32'(bus.write_en_o), 32'd1);
    check("single_credits", 32'(bus.credit_count_o), 32'd4);
    check("single_empty", 32'(bus.empty_o), 32'd1);
    cycle(0, '0, 0, 0);
    check("single_we_off", 32'(bus.write_en_o), 32'd0);

    // Credit exhaustion: 9 flits, only 5 leave; one credit releases flit 6.
    cycle(0, '0, 0, 1);
    for (int k = 1; k <= 9; k++) cycle(1, 16'(k), 0, 0);
    check("exh_credits", 32'(bus.credit_count_o), 32'd0);
    check("exh_ready", 32'(bus.ready_o), 32'd0);
    cycle(0, '0, 0, 0);
    check("exh_we_blocked", 32'(bus.write_en_o), 32'd0);
    cycle(0, '0, 1, 0);
    check("exh_flit6", 32'(bus.data_o), 32'd6);
    check("exh_flit6_we", 32'(bus.write_en_o), 32'd1);
    check("exh_credit_after", 32'(bus.credit_count_o), 32'd0);
    check("exh_ready_after", 32'(bus.ready_o), 32'd1);
    cycle(0, '0, 0, 0);
    check("exh_single_release", 32'(bus.write_en_o), 32'd0);

    // Simultaneous credit and send at credits=2.
    cycle(0, '0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(1, 16'(16'h30 + k), 0, 0);
    cycle(0, '0, 0, 0);
    check("sim_credits_start", 32'(bus.credit_count_o), 32'd2);
    cycle(1, 16'h0040, 0, 0);
    for (int k = 1; k < 6; k++) begin
      cycle(1, 16'(16'h40 + k), 1, 0);
      check("sim_credits_hold", 32'(bus.credit_count_o), 32'd2);
      check("sim_order", 32'(bus.data_o), 32'(16'h40 + k - 1));
    end
    cycle(0, '0, 1, 0);
    check("sim_last", 32'(bus.data_o), 32'h45);

    // Credit overflow is sticky until reset.
    cycle(0, '0, 0, 1);
    cycle(0, '0, 1, 0);
    check("ovf_credits", 32'(bus.credit_count_o), 32'd5);
    check("ovf_err", 32'(bus.credit_err_o), 32'd1);
    for (int k = 0; k < 4; k++) cycle(1, 16'(16'h70 + k), 0, 0);
    cycle(0, '0, 0, 0);
    check("ovf_err_sticky", 32'(bus.credit_err_o), 32'd1);
    cycle(0, '0, 0, 1);
    check("ovf_err_cleared", 32'(bus.credit_err_o), 32'd0);

    // Reset mid-burst with flits queued.
    for (int k = 0; k < 8; k++) cycle(1, 16'(16'h90 + k), 0, 0);
    cycle(0, '0, 1, 1);
    check("mid_we", 32'(bus.write_en_o), 32'd0);
    check("mid_empty", 32'(bus.empty_o), 32'd1);
    check("mid_credits", 32'(bus.credit_count_o), 32'd5);
    for (int k = 0; k < 3; k++) begin
      cycle(0, '0, 0, 0);
      check("mid_no_stale", 32'(bus.write_en_o), 32'd0);
    end

    // Randomized traffic with a downstream buffer that pops at random.
    ds = 0;
    for (int k = 0; k < 600; k++) begin
      rr = ($urandom_range(0, 149) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rc = (ds > 0) && ($urandom_range(0, 2) != 0);
      cycle(rv, 16'($urandom), rc, rr);
      if (rr) ds = 0;
      else    ds = ds - int'(rc) + int'(bus.write_en_o);
      check("ds_no_overflow", 32'(ds <= int'(CREDITS)), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
